// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode and FSM state types for alu_multicycle, plus a
//             helper that identifies the iterative (multi-cycle) opcodes.
//  Ports    : n/a (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_SLTU = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOR  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MULU = 4'd11,
    OP_DIVU = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // MULU and DIVU go through the shared iterative datapath.
  function automatic logic op_is_multicycle(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : alu_iter_muldiv
//  Purpose  : Shared WIDTH-iteration datapath: shift-add unsigned multiply or
//             restoring unsigned divide, one bit per cycle.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             start           - load operands and perform the first iteration
//             mode_div        - 1 = divide (a/b), 0 = multiply (a*b)
//             op_a, op_b      - operands, sampled only when start=1
//             res_lo          - low product / quotient
//             res_hi          - high product / remainder
//             done            - all WIDTH iterations complete
//  Revision : 1.0 - initial release
// ============================================================================
module alu_iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // acc: high product / partial remainder; shr: multiplier / dividend that
  // shifts out while product / quotient bits shift in; opnd: multiplicand / divisor.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] src_acc, src_shr, src_opnd;
  logic             src_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  always_comb begin
    // The first iteration runs on the start edge straight from the operands,
    // so WIDTH iterations finish WIDTH-1 cycles after start.
    src_acc  = start ? '0 : acc_q;
    src_shr  = start ? (mode_div ? op_a : op_b) : shr_q;
    src_opnd = start ? (mode_div ? op_b : op_a) : opnd_q;
    src_div  = start ? mode_div : div_q;

    mul_sum   = {1'b0, src_acc} + (src_shr[0] ? {1'b0, src_opnd} : '0);
    div_trial = {src_acc, src_shr[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, src_opnd};
    // When div_ge holds, the true difference is below the divisor, so the
    // low WIDTH bits are exact.
    div_diff  = div_trial[WIDTH-1:0] - src_opnd;

    acc_d  = acc_q;
    shr_d  = shr_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;

    if (start || (cnt_q != '0)) begin
      opnd_d = src_opnd;
      div_d  = src_div;
      cnt_d  = start ? CNT_W'(WIDTH - 1) : cnt_q - CNT_W'(1);
      if (src_div) begin
        acc_d = div_ge ? div_diff : div_trial[WIDTH-1:0];
        shr_d = {src_shr[WIDTH-2:0], div_ge};
      end else begin
        acc_d = mul_sum[WIDTH:1];
        shr_d = {mul_sum[0], src_shr[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      shr_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      shr_q  <= shr_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign res_lo = shr_q;
  assign res_hi = acc_q;
  assign done   = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle
//  Purpose  : WIDTH-bit ALU with registered results and valid/ready
//             handshakes; single-cycle logic/arith/shift ops plus iterative
//             unsigned multiply and divide.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             in_valid / in_ready  - operand handshake (ready only in IDLE)
//             a, b, alu_control    - operands and opcode
//             out_valid / out_ready- result handshake
//             result, result_hi    - primary / secondary result
//             zero, carry, overflow, div_by_zero - status flags
//  Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic             zero_q, zero_d, carry_q, carry_d;
  logic             overflow_q, overflow_d, dbz_q, dbz_d;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry, sc_overflow, sc_defined;

  always_comb begin
    add_w       = {1'b0, a} + {1'b0, b};
    sub_w       = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    shamt       = b[SHAMT_W-1:0];
    sc_result   = '0;
    sc_carry    = 1'b0;
    sc_overflow = 1'b0;
    sc_defined  = 1'b1;
    case (alu_control)
      OP_ADD: begin
        sc_result   = add_w[WIDTH-1:0];
        sc_carry    = add_w[WIDTH];
        sc_overflow = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_result   = sub_w[WIDTH-1:0];
        sc_carry    = sub_w[WIDTH];
        sc_overflow = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  sc_result = a ^ b;
      OP_NOR:  sc_result = ~(a | b);
      OP_SLL:  sc_result = a << shamt;
      OP_SRL:  sc_result = a >> shamt;
      OP_SRA:  sc_result = $signed(a) >>> shamt;
      default: sc_defined = 1'b0;  // opcodes 13-15 give all-zero outputs
    endcase
  end

  // ---------------- iterative multiply / divide ----------------
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign md_start = in_valid && in_ready && op_is_multicycle(alu_control);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .mode_div (alu_control == OP_DIVU),
    .op_a     (a),
    .op_b     (b),
    .res_lo   (md_lo),
    .res_hi   (md_hi),
    .done     (md_done)
  );

  // ---------------- FSM and output registers ----------------
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d  = a;
          b_d  = b;
          op_d = alu_control;
          if (op_is_multicycle(alu_control)) begin
            state_d = BUSY;
          end else begin
            state_d     = DONE;
            result_d    = sc_result;
            result_hi_d = '0;
            zero_d      = sc_defined && (sc_result == '0);
            carry_d     = sc_carry;
            overflow_d  = sc_overflow;
            dbz_d       = 1'b0;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d    = DONE;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          if ((op_q == OP_DIVU) && (b_q == '0)) begin
            result_d    = '1;
            result_hi_d = a_q;
            dbz_d       = 1'b1;
          end else begin
            result_d    = md_lo;
            result_hi_d = md_hi;
            dbz_d       = 1'b0;
          end
          zero_d = (result_d == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_multicycle
//  Purpose  : Self-checking bench for alu_multicycle (WIDTH=16): directed
//             corner cases, backpressure, reset mid-operation, and random ops
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result, result_hi;
  logic [3:0]   alu_control;
  logic         zero, carry, overflow, div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        z;
    logic        c;
    logic        v;
    logic        d;
  } exp_t;

  function automatic exp_t outs();
    exp_t o;
    o = {result, result_hi, zero, carry, overflow, div_by_zero};
    return o;
  endfunction

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input int op, input logic [15:0] x, input logic [15:0] y);
    exp_t   e;
    int     ux, uy, sx, sy, r, sh;
    longint p;
    e  = '0;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    sh = uy % 16;
    case (op)
      0: begin r = ux + uy; e.res = 16'(r); e.c = (r > 65535);
               e.v = (sx + sy > 32767) || (sx + sy < -32768); end
      1: begin r = ux - uy; e.res = 16'(r); e.c = (ux >= uy);
               e.v = (sx - sy > 32767) || (sx - sy < -32768); end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = (sx < sy) ? 16'd1 : 16'd0;
      5: e.res = (ux < uy) ? 16'd1 : 16'd0;
      6: e.res = x ^ y;
      7: e.res = ~(x | y);
      8: begin r = ux << sh; e.res = 16'(r); end
      9: begin r = ux >> sh; e.res = 16'(r); end
      10: begin r = sx >>> sh; e.res = 16'(r); end
      11: begin p = longint'(ux) * longint'(uy); e.res = 16'(p); e.hi = 16'(p >> 16); end
      12: begin
        if (uy == 0) begin e.res = 16'hFFFF; e.hi = x; e.d = 1'b1; end
        else begin e.res = 16'(ux / uy); e.hi = 16'(ux % uy); end
      end
      default: return e;
    endcase
    e.z = (e.res == 16'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, wait for the result, check latency, outputs,
  // optional backpressure hold, and drain.
  task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                        input int hold, input string tag);
    exp_t e, snap;
    int   cyc;
    bit   multi, busy_ok, stable;
    e     = model(int'(op), x, y);
    multi = (op == 4'd11) || (op == 4'd12);
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid    = 1'b1;
    a           = x;
    b           = y;
    alu_control = op;
    out_ready   = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    cyc      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, cyc, multi ? 17 : 1);
    if (multi) chk({tag, ".busy_in_ready"}, busy_ok, 1);
    chk({tag, ".outputs"}, outs(), e);
    if (hold > 0) begin
      snap   = outs();
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!out_valid || in_ready || (outs() !== snap)) stable = 1'b0;
      end
      chk({tag, ".hold_stable"}, stable, 1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, ".drain"}, out_valid, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z0;
    bit   seen;
    logic [3:0]  rop;
    logic [15:0] rx, ry;

    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    alu_control = '0;
    z0          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset.outputs", outs(), z0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.in_ready", in_ready, 1);

    // Directed corner cases
    run_op(4'd0,  16'h7FFF, 16'h0001, 0, "add_ovf");
    run_op(4'd1,  16'h0005, 16'h0005, 0, "sub_zero");
    run_op(4'd4,  16'hFFFF, 16'h0001, 0, "slt");
    run_op(4'd5,  16'hFFFF, 16'h0001, 0, "sltu");
    run_op(4'd10, 16'h8000, 16'h0004, 0, "sra");
    run_op(4'd8,  16'h0001, 16'h0013, 0, "sll_mask");
    run_op(4'd11, 16'hFFFF, 16'hFFFF, 0, "mulu_max");
    run_op(4'd12, 16'd100,  16'd7,    0, "divu");
    run_op(4'd12, 16'h1234, 16'h0000, 0, "divu_by0");
    run_op(4'd14, 16'h1234, 16'h5678, 0, "undef");
    run_op(4'd1,  16'h8000, 16'h0001, 0, "sub_ovf");
    run_op(4'd0,  16'hFFFF, 16'h0001, 0, "add_carry");

    // Backpressure on both paths
    run_op(4'd6,  16'hA5A5, 16'h0FF0, 5, "bp_xor");
    run_op(4'd11, 16'h1234, 16'h5678, 5, "bp_mulu");

    // Reset in the middle of a MULU
    in_valid    = 1'b1;
    a           = 16'hFFFF;
    b           = 16'h1234;
    alu_control = 4'd11;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset.outputs", outs(), z0);
    chk("midreset.out_valid", out_valid, 0);
    chk("midreset.in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midreset.no_valid", seen, 0);
    run_op(4'd11, 16'h00FF, 16'h0101, 0, "after_reset_mulu");
    run_op(4'd12, 16'hFFFF, 16'h0010, 0, "after_reset_divu");

    // Random operations
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = 16'($urandom);
      ry  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      run_op(rop, rx, ry, int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
